mult_seq: RTL and testbench



---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_seq_mcla32.sv | 51 +++++
 rtl/mult_seq.sv | 171 +++++++++++++++++
 tb/tb_mult_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential MULT/MULTU unit.
// Optional signed support is enabled by defining MULT_SIGNED_EN.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    FIX_A = 3'd2,
    FIX_B = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int MULT_N_BITS = 32;
  localparam int MULT_ITER   = 32;

endpackage

// File: rtl/mult_seq_mcla32.sv
// 32-bit two-level carry-lookahead adder (4-bit groups, 8-group lookahead).
// Shared by the multiplier for both accumulation and HI correction.
module MCLA32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [7:0]  w_gg;
  logic [7:0]  w_gp;
  logic [8:0]  w_gc;
  logic [32:0] w_c;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    for (int i = 0; i < 8; i++) begin
      w_gg[i] = w_g[4*i+3]
              | (w_p[4*i+3] & w_g[4*i+2])
              | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
              | ((&w_p[4*i+3 -: 3]) & w_g[4*i]);
      w_gp[i] = &w_p[4*i +: 4];
    end
    // group carries resolve before any in-group ripple
    w_gc[0] = cin_i;
    for (int i = 0; i < 8; i++) begin
      w_gc[i+1] = w_gg[i] | (w_gp[i] & w_gc[i]);
    end
    for (int i = 0; i < 8; i++) begin
      w_c[4*i] = w_gc[i];
      for (int j = 0; j < 3; j++) begin
        w_c[4*i+j+1] = w_g[4*i+j]
                     | (w_p[4*i+j] & w_c[4*i+j]);
      end
    end
    w_c[32] = w_gc[8];
  end

  assign sum_o  = w_p ^ w_c[31:0];
  assign cout_o = w_c[32];

endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-add 32x32 multiplier with start/busy/done handshake.
// Define MULT_SIGNED_EN for MULT support (HI correction in FIX_A/FIX_B).
module mult_seq
  import mult_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        cancel_i,
  input  logic        signed_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  if (N_BITS != MULT_N_BITS || CNT_W != $clog2(N_BITS))
  begin : g_bad_width
    $error("mult_seq: N_BITS must be 32, CNT_W 5");
  end

  state_t r_state;
  state_t w_next;

  logic [32:0]      r_acc;
  logic [31:0]      r_mplier;
  logic [31:0]      r_mcand;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

`ifdef MULT_SIGNED_EN
  logic [31:0] r_opb;
  logic        r_sgn_a;
  logic        r_sgn_b;
`endif

  logic [31:0] w_add_b;
  logic        w_cin;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [64:0] w_shift;
  logic [32:0] w_acc_nxt;
  logic [31:0] w_mpl_nxt;
  logic        w_last;
  logic        w_unused;

  MCLA32 u_cla (
    .a_i    (r_acc[31:0]),
    .b_i    (w_add_b),
    .cin_i  (w_cin),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  // the shift always clears acc[32]; it is kept only as the carry slot
`ifdef MULT_SIGNED_EN
  assign w_unused = r_acc[32];
`else
  assign w_unused = r_acc[32] ^ signed_i;
`endif

  assign w_shift = {w_cout, w_sum, r_mplier} >> 1;
  assign w_last  = (r_cnt == CNT_W'(MULT_ITER - 1));

  always_comb begin
    w_add_b   = r_mplier[0] ? r_mcand : '0;
    w_cin     = 1'b0;
    w_acc_nxt = r_acc;
    w_mpl_nxt = r_mplier;
    unique case (r_state)
      CALC: begin
        w_acc_nxt = w_shift[64:32];
        w_mpl_nxt = w_shift[31:0];
      end
`ifdef MULT_SIGNED_EN
      FIX_A: begin
        w_add_b   = ~(r_sgn_a ? r_opb : 32'd0);
        w_cin     = 1'b1;
        w_acc_nxt = {1'b0, w_sum};
      end
      FIX_B: begin
        w_add_b   = ~(r_sgn_b ? r_mcand : 32'd0);
        w_cin     = 1'b1;
        w_acc_nxt = {1'b0, w_sum};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_i && !cancel_i) w_next = CALC;
      end
      CALC: begin
        if (cancel_i) begin
          w_next = IDLE;
        end else if (w_last) begin
`ifdef MULT_SIGNED_EN
          w_next = FIX_A;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      FIX_A: w_next = cancel_i ? IDLE : FIX_B;
      FIX_B: w_next = cancel_i ? IDLE : DONE;
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MULT_SIGNED_EN
      r_opb    <= '0;
      r_sgn_a  <= 1'b0;
      r_sgn_b  <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE) begin
        if (w_next == CALC) begin
          r_acc    <= '0;
          r_mplier <= op_b_i;
          r_mcand  <= op_a_i;
          r_cnt    <= '0;
`ifdef MULT_SIGNED_EN
          r_opb    <= op_b_i;
          r_sgn_a  <= signed_i & op_a_i[31];
          r_sgn_b  <= signed_i & op_b_i[31];
`endif
        end
      end else if (r_state != DONE && !cancel_i) begin
        r_acc    <= w_acc_nxt;
        r_mplier <= w_mpl_nxt;
        if (r_state == CALC) r_cnt <= r_cnt + 1'b1;
      end
      if (w_next == DONE && r_state != DONE) begin
        r_hi <= w_acc_nxt[31:0];
        r_lo <= w_mpl_nxt;
      end
    end
  end

  assign busy_o = (r_state != IDLE);
  assign done_o = (r_state == DONE);
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corners plus random
// operands against a 64-bit arithmetic reference model.
module tb_mult_seq;

`ifdef MULT_SIGNED_EN
  localparam int LAT = 35;
  localparam bit SGN = 1'b1;
`else
  localparam int LAT = 33;
  localparam bit SGN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        cancel_i;
  logic        signed_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_pass;
  int n_total;

  mult_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .cancel_i (cancel_i),
    .signed_i (signed_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    logic [63:0] xa;
    logic [63:0] xb;
    xa = {32'd0, a};
    xb = {32'd0, b};
    if (s && SGN) begin
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
    end
    return xa * xb;
  endfunction

  // Drives one operation; optional stray start / cancel at given edges.
  task automatic do_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    input  int          inj_at,
    input  int          cxl_at,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output int          lat,
    output bit          busy_ok
  );
    int edges;
    busy_ok = 1'b1;
    lat     = -1;
    @(negedge clk);
    start_i  = 1'b1;
    op_a_i   = a;
    op_b_i   = b;
    signed_i = s;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    for (int k = 0; k < 60; k++) begin
      start_i  = 1'b0;
      cancel_i = 1'b0;
      if (!busy_o) busy_ok = 1'b0;
      if (done_o) begin
        lat = edges;
        break;
      end
      if (edges == inj_at) begin
        start_i = 1'b1;
        op_a_i  = 32'd2;
        op_b_i  = 32'd2;
      end
      if (edges == cxl_at) cancel_i = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start_i  = 1'b0;
    cancel_i = 1'b0;
    hi = hi_o;
    lo = lo_o;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    signed_i = 1'b0;
    op_a_i   = '0;
    op_b_i   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({busy_o, done_o} !== 2'b00)
      $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy_o, done_o);
    else n_pass++;
    n_total++;
    if ({hi_o, lo_o} !== 64'd0)
      $display("FAIL reset_hilo got %h_%h want 0", hi_o, lo_o);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max;
    logic [31:0] hi, lo;
    int lat;
    bit bok;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1, hi, lo, lat, bok);
    n_total++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL umax_result got %h_%h want fffffffe_00000001", hi, lo);
    else n_pass++;
    n_total++;
    if (lat !== LAT)
      $display("FAIL umax_latency got %0d want %0d", lat, LAT);
    else n_pass++;
    n_total++;
    if (bok !== 1'b1)
      $display("FAIL umax_busy got low during op want high");
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({busy_o, done_o} !== 2'b00)
      $display("FAIL umax_after_done got busy=%b done=%b want 0 0", busy_o, done_o);
    else n_pass++;
    n_total++;
    if ({hi_o, lo_o} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL umax_hold got %h_%h want fffffffe_00000001", hi_o, lo_o);
    else n_pass++;
  endtask

  task automatic test_signed_mixed;
    logic [31:0] hi, lo;
    logic [63:0] want;
    int lat;
    bit bok;
`ifdef MULT_SIGNED_EN
    want = 64'hFFFF_FFFF_FFFF_FFEB;
`else
    want = 64'h0000_0006_FFFF_FFEB;
`endif
    do_op(32'hFFFF_FFFD, 32'd7, 1'b1, -1, -1, hi, lo, lat, bok);
    n_total++;
    if ({hi, lo} !== want)
      $display("FAIL signed_mixed got %h_%h want %h", hi, lo, want);
    else n_pass++;
    n_total++;
    if (lat !== LAT)
      $display("FAIL signed_mixed_lat got %0d want %0d", lat, LAT);
    else n_pass++;
  endtask

  task automatic test_signed_corner;
    logic [31:0] hi, lo;
    logic [63:0] want;
    int lat;
    bit bok;
`ifdef MULT_SIGNED_EN
    want = 64'h4000_0000_0000_0000;
`else
    want = 64'h4000_0000_0000_0000;
`endif
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, -1, hi, lo, lat, bok);
    n_total++;
    if ({hi, lo} !== want)
      $display("FAIL signed_corner got %h_%h want %h", hi, lo, want);
    else n_pass++;
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, -1, -1, hi, lo, lat, bok);
    want = ref_mul(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    n_total++;
    if ({hi, lo} !== want)
      $display("FAIL min_times_max got %h_%h want %h", hi, lo, want);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] hi, lo, a, b;
    logic [63:0] want;
    logic s;
    int lat;
    bit bok;
    int errs;
    errs = 0;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 6 == 0) a = 32'd0;
      if (i % 6 == 1) b = 32'd1;
      do_op(a, b, s, -1, -1, hi, lo, lat, bok);
      want = ref_mul(a, b, s);
      n_total++;
      if ({hi, lo} !== want || lat !== LAT) begin
        $display("FAIL random_%0d a=%h b=%h s=%b got %h_%h lat %0d want %h lat %0d",
                 i, a, b, s, hi, lo, lat, want, LAT);
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] hi, lo;
    int lat;
    bit bok;
    do_op(32'd5, 32'd6, 1'b0, 5, -1, hi, lo, lat, bok);
    n_total++;
    if ({hi, lo} !== 64'd30 || lat !== LAT)
      $display("FAIL ignored_start got %h_%h lat %0d want 0_1e lat %0d", hi, lo, lat, LAT);
    else n_pass++;
    do_op(32'd2, 32'd2, 1'b0, -1, -1, hi, lo, lat, bok);
    n_total++;
    if ({hi, lo} !== 64'd4 || lat !== LAT)
      $display("FAIL b2b_start got %h_%h lat %0d want 0_4 lat %0d", hi, lo, lat, LAT);
    else n_pass++;
  endtask

  task automatic test_cancel;
    logic [31:0] hi, lo;
    int lat;
    bit bok;
    do_op(32'd5, 32'd6, 1'b0, -1, -1, hi, lo, lat, bok);
    do_op(32'h1234, 32'h10, 1'b0, -1, 10, hi, lo, lat, bok);
    n_total++;
    if (lat !== -1)
      $display("FAIL cancel_no_done got done at edge %0d want none", lat);
    else n_pass++;
    n_total++;
    if ({hi, lo} !== 64'd30 || busy_o !== 1'b0)
      $display("FAIL cancel_hold got %h_%h busy=%b want 0_1e busy=0", hi, lo, busy_o);
    else n_pass++;
    do_op(32'd3, 32'd3, 1'b0, -1, -1, hi, lo, lat, bok);
    n_total++;
    if ({hi, lo} !== 64'd9 || lat !== LAT)
      $display("FAIL after_cancel got %h_%h lat %0d want 0_9 lat %0d", hi, lo, lat, LAT);
    else n_pass++;
  endtask

  task automatic test_reset_midop;
    logic [31:0] hi, lo;
    int lat;
    bit bok;
    @(negedge clk);
    start_i  = 1'b1;
    op_a_i   = 32'h1234_5678;
    op_b_i   = 32'h8765_4321;
    signed_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
`ifdef MULT_SIGNED_EN
    repeat (32) @(posedge clk);
`else
    repeat (19) @(posedge clk);
`endif
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy_o, done_o} !== 2'b00 || {hi_o, lo_o} !== 64'd0)
      $display("FAIL midop_reset got busy=%b done=%b %h_%h want all 0",
               busy_o, done_o, hi_o, lo_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd1, 32'd1, 1'b0, -1, -1, hi, lo, lat, bok);
    n_total++;
    if ({hi, lo} !== 64'd1 || lat !== LAT)
      $display("FAIL after_reset got %h_%h lat %0d want 0_1 lat %0d", hi, lo, lat, LAT);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_unsigned_max();
    test_signed_mixed();
    test_signed_corner();
    test_random();
    test_back_to_back();
    test_cancel();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
